uart_frame_scheduler: RTL and testbench
=======================================

// Module: uart_frame_scheduler
// PURPOSE
// - Sequences the per-frame player-2 state (x, y, start flag) into the shared 16-bit UART path as tagged words.
// - Sits between the mouse/menu position muxes and the UART 16->8 converter.
// - Snapshots all fields once per frame so the peer always receives a coherent set.
// - Paces words on converter ready / tx_done handshakes and aborts on a stalled link.
// PARAMETERS
// - NWORDS       3        words per frame (tags 1..NWORDS); fixed to 3 in this revision
// - TIMEOUT_CYC  65000    max cycles waiting for ready or tx_done on one word (~1 ms @ 65 MHz)
// - CNT_W        8        width of the saturating statistics counters
// PORTS
// - clk           in   1      pixel clock (65 MHz)
// - rst           in   1      asynchronous, active-high reset
// - frame_tick    in   1      one-cycle strobe, start of a new frame (vsync edge)
// - pl2_posx      in   12     player-2 x position, sampled at frame start
// - pl2_posy      in   12     player-2 y position, sampled at frame start
// - start_game    in   1      start-game flag, sampled at frame start
// - conv16to8ready in  1      converter can accept a 16-bit word this cycle
// - tx_done       in   1      one-cycle pulse, current word fully shifted out
// - data          out  16     word to converter: [15:12] tag, [11:0] payload
// - data_valid    out  1      data is valid; held until accepted (valid & ready)
// - busy          out  1      a frame is in progress
// - frame_done    out  1      one-cycle pulse, all words of a frame sent
// - drop_cnt      out  CNT_W  frames dropped (tick while busy with pending already set), saturating
// - timeout_cnt   out  CNT_W  frames aborted by timeout, saturating
// BEHAVIOUR
// - Reset: all outputs 0; state IDLE; pending 0; snapshot registers 0.
// - Word format: tag 4'h1 = {posx}; tag 4'h2 = {posy}; tag 4'h3 = {11'b0, start_game}.
// - FSM: IDLE -> LOAD -> OFFER -> WAIT_DONE -> (OFFER for next word | FINISH) -> IDLE.
// - IDLE: on frame_tick or pending, go to LOAD and clear pending. The frame_tick path takes 1 cycle.
// - LOAD: capture posx/posy/start_game into the snapshot; word index <= 0; busy <= 1.
// - OFFER: data_valid = 1 and data = word[index]. Both are registered outputs and stay stable until
//   valid & conv16to8ready; on acceptance drop data_valid in the next cycle and go to WAIT_DONE.
// - WAIT_DONE: on tx_done, if index == NWORDS-1 go to FINISH, else index++ and go to OFFER.
//   tx_done seen in any other state is ignored.
// - FINISH: one cycle; frame_done = 1, busy <= 0, then IDLE. IDLE -> LOAD may follow in the next cycle.
// - Timeout: the watchdog counter clears on every state entry and counts in OFFER and WAIT_DONE.
//   Reaching TIMEOUT_CYC-1 aborts the frame: data_valid <= 0, timeout_cnt++ (saturating), go to IDLE,
//   no frame_done. Pending is kept.
// - frame_tick while busy (any state other than IDLE) sets pending. A tick while pending is already set
//   increments drop_cnt (saturating).
// - frame_tick in the same cycle as FINISH sets pending, so the next frame starts without loss.
// - Inputs change mid-frame: no effect; only snapshot values are transmitted.
// - rst asserted mid-frame: immediate return to reset values. A partially sent frame is not resumed.
// - Latency: frame_tick -> first data_valid = 2 cycles (IDLE -> LOAD -> OFFER).
// STRUCTURE
// - Shared package/header (alongside the VGA macros): tag constants UART_TAG_POSX/POSY/CTRL, word field
//   bit ranges, and the state encoding localparams.
// - One natural sub-module, sat_counter (parameterised width, inc, async rst), instantiated for
//   drop_cnt and timeout_cnt.
// - FSM, snapshot, word mux and watchdog stay inline.
// TESTING
// - Reset then tick with posx=50, posy=679, start=0, ready=1, tx_done 10 cycles after each accept ->
//   words 16'h1032, 16'h22A7, 16'h3000 in order; frame_done once; busy high throughout.
// - ready held low 5 cycles during OFFER -> data and data_valid stable, exactly one accept.
// - Change posx to 100 right after LOAD -> the frame still sends 16'h1032.
// - Two ticks during one frame -> one extra frame follows; drop_cnt=1. Tick coincident with FINISH ->
//   next frame starts, drop_cnt unchanged.
// - tx_done never arrives -> abort after TIMEOUT_CYC; timeout_cnt=1; no frame_done; next tick works.
// - Assert rst while in WAIT_DONE -> all outputs 0 the same cycle; 300 drops saturate drop_cnt at 255.

Source files
------------

// File: rtl/uart_frame_scheduler_pkg.sv
// rtl/uart_frame_scheduler_pkg.sv - shared tags, word layout and FSM encoding for the UART frame scheduler
// Purpose: constants and types shared by uart_frame_scheduler and its bench.
//   UART_TAG_*   : 4-bit word tags placed in data[15:12]
//   TAG_W/PAY_W  : tag and payload field widths of the 16-bit word
//   state_e      : scheduler FSM encoding
//   snap_t       : per-frame snapshot of the transmitted fields
//   make_word    : builds the tagged word for a given word index
package uart_frame_scheduler_pkg;

  localparam int TAG_W = 4;
  localparam int PAY_W = 12;

  localparam logic [TAG_W-1:0] UART_TAG_POSX = 4'h1;
  localparam logic [TAG_W-1:0] UART_TAG_POSY = 4'h2;
  localparam logic [TAG_W-1:0] UART_TAG_CTRL = 4'h3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_OFFER     = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_FINISH    = 3'd4
  } state_e;

  typedef struct packed {
    logic [PAY_W-1:0] posx;
    logic [PAY_W-1:0] posy;
    logic             start;
  } snap_t;

  // Word order: 0 = posx, 1 = posy, anything else = control word.
  function automatic logic [TAG_W+PAY_W-1:0] make_word(input logic [1:0] idx, input snap_t s);
    case (idx)
      2'd0:    return {UART_TAG_POSX, s.posx};
      2'd1:    return {UART_TAG_POSY, s.posy};
      default: return {UART_TAG_CTRL, {(PAY_W-1){1'b0}}, s.start};
    endcase
  endfunction

endpackage

// File: rtl/uart_frame_scheduler_sat_counter.sv
// rtl/uart_frame_scheduler_sat_counter.sv - saturating event counter
// Purpose: counts single-cycle inc pulses, sticking at all-ones.
// Ports:
//   clk   in  1  clock
//   rst   in  1  asynchronous active-high reset, clears the count
//   inc   in  1  increment request
//   count out W  current count
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/uart_frame_scheduler.sv
// rtl/uart_frame_scheduler.sv - per-frame player-2 state sequencer onto the 16-bit UART path
// Purpose: snapshots posx/posy/start_game on each frame tick and offers them as three
//   tagged words to the 16->8 converter, pacing on ready/tx_done with a stall watchdog.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   frame_tick        start-of-frame strobe
//   pl2_posx/posy     12-bit positions, start_game flag (sampled in LOAD)
//   conv16to8ready    converter accepts data this cycle
//   tx_done           current word fully shifted out
//   data/data_valid   tagged word offered to the converter
//   busy, frame_done  frame in progress / frame completed pulse
//   drop_cnt          frames dropped, timeout_cnt frames aborted (saturating)
module uart_frame_scheduler
  import uart_frame_scheduler_pkg::*;
#(
  parameter int NWORDS      = 3,
  parameter int TIMEOUT_CYC = 65000,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_tick,
  input  logic [11:0]      pl2_posx,
  input  logic [11:0]      pl2_posy,
  input  logic             start_game,
  input  logic             conv16to8ready,
  input  logic             tx_done,
  output logic [15:0]      data,
  output logic             data_valid,
  output logic             busy,
  output logic             frame_done,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [CNT_W-1:0] timeout_cnt
);

  localparam int IDX_W = 2;
  localparam int WD_W  = $clog2(TIMEOUT_CYC);

  state_e          state_q, state_d;
  snap_t           snap_q, snap_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [15:0]     data_q, data_d;
  logic            valid_q, valid_d;
  logic            busy_q, busy_d;
  logic            pend_q, pend_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            drop_inc;
  logic            tmo_inc;
  logic            wd_expired;
  snap_t           snap_in;

  assign snap_in    = '{posx: pl2_posx, posy: pl2_posy, start: start_game};
  assign wd_expired = (wd_q == WD_W'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d  = state_q;
    snap_d   = snap_q;
    idx_d    = idx_q;
    data_d   = data_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    pend_d   = pend_q;
    drop_inc = 1'b0;
    tmo_inc  = 1'b0;

    // A tick outside IDLE (FINISH included) is queued once; further ticks are dropped.
    if (frame_tick && (state_q != ST_IDLE)) begin
      if (pend_q) drop_inc = 1'b1;
      else        pend_d   = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (frame_tick || pend_q) begin
          pend_d  = 1'b0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // First word is built from the live inputs since the snapshot is being captured now.
        snap_d  = snap_in;
        idx_d   = '0;
        busy_d  = 1'b1;
        data_d  = make_word(2'd0, snap_in);
        valid_d = 1'b1;
        state_d = ST_OFFER;
      end
      ST_OFFER: begin
        if (valid_q && conv16to8ready) begin
          valid_d = 1'b0;
          state_d = ST_WAIT_DONE;
        end else if (wd_expired) begin
          valid_d = 1'b0;
          busy_d  = 1'b0;
          tmo_inc = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_DONE: begin
        if (tx_done) begin
          if (idx_q == IDX_W'(NWORDS - 1)) begin
            state_d = ST_FINISH;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            data_d  = make_word(idx_q + IDX_W'(1), snap_q);
            valid_d = 1'b1;
            state_d = ST_OFFER;
          end
        end else if (wd_expired) begin
          busy_d  = 1'b0;
          tmo_inc = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_FINISH: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Watchdog restarts on every state change and only runs while waiting on the link.
    if (state_d != state_q) begin
      wd_d = '0;
    end else if ((state_q == ST_OFFER) || (state_q == ST_WAIT_DONE)) begin
      wd_d = wd_q + WD_W'(1);
    end else begin
      wd_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      snap_q  <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      pend_q  <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      pend_q  <= pend_d;
      wd_q    <= wd_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_drop_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (drop_inc),
    .count (drop_cnt)
  );

  sat_counter #(.W(CNT_W)) u_timeout_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (tmo_inc),
    .count (timeout_cnt)
  );

  assign data       = data_q;
  assign data_valid = valid_q;
  assign busy       = busy_q;
  assign frame_done = (state_q == ST_FINISH);

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// tb/tb_uart_frame_scheduler.sv - scoreboard bench for uart_frame_scheduler
module tb_uart_frame_scheduler;

  localparam int TMO = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_tick = 1'b0;
  logic [11:0] posx = '0;
  logic [11:0] posy = '0;
  logic        start_game = 1'b0;
  logic        ready = 1'b0;
  logic        tx_done = 1'b0;
  logic [15:0] data;
  logic        data_valid;
  logic        busy;
  logic        frame_done;
  logic [7:0]  drop_cnt;
  logic [7:0]  timeout_cnt;

  int          n_vec = 0;
  int          n_err = 0;
  int          done_cnt = 0;
  logic [15:0] exp_q[$];
  bit          txd_en = 1'b0;
  logic        stall_prev = 1'b0;
  logic [15:0] stall_data = '0;

  uart_frame_scheduler #(.NWORDS(3), .TIMEOUT_CYC(TMO), .CNT_W(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .frame_tick     (frame_tick),
    .pl2_posx       (posx),
    .pl2_posy       (posy),
    .start_game     (start_game),
    .conv16to8ready (ready),
    .tx_done        (tx_done),
    .data           (data),
    .data_valid     (data_valid),
    .busy           (busy),
    .frame_done     (frame_done),
    .drop_cnt       (drop_cnt),
    .timeout_cnt    (timeout_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every accepted word pops one expected word.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_done) done_cnt++;
      if (data_valid && ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_word: got %0h expected none", data);
        end else begin
          check("word", {16'h0, data}, {16'h0, exp_q.pop_front()});
        end
      end
      if (stall_prev && data_valid) check("stall_hold", {16'h0, data}, {16'h0, stall_data});
    end
    stall_prev = !rst && data_valid && !ready;
    stall_data = data;
  end

  // Link model: tx_done about 10 cycles after each accepted word.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && data_valid && ready && txd_en) begin
        repeat (10) @(posedge clk);
        #1 tx_done = 1'b1;
        @(posedge clk);
        #1 tx_done = 1'b0;
      end
    end
  end

  task automatic tick_once();
    @(posedge clk);
    #1 frame_tick = 1'b1;
    @(posedge clk);
    #1 frame_tick = 1'b0;
  endtask

  task automatic wait_done(input int target, input string name);
    int i = 0;
    while (done_cnt < target && i < 3000) begin
      @(negedge clk);
      i++;
    end
    check(name, {31'h0, done_cnt >= target}, 32'h1);
  endtask

  task automatic wait_accept(input string name);
    int i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (!(data_valid && ready) && i < 200);
    check(name, {31'h0, data_valid && ready}, 32'h1);
  endtask

  task automatic push3(input logic [11:0] x, input logic [11:0] y, input logic s);
    exp_q.push_back({4'h1, x});
    exp_q.push_back({4'h2, y});
    exp_q.push_back({4'h3, 11'h0, s});
  endtask

  initial begin
    int base;
    int i;

    // Reset state
    @(negedge clk);
    check("reset_outputs", {8'h0, data, data_valid, busy, frame_done, 5'h0},
          32'h0);
    check("reset_counters", {16'h0, drop_cnt, timeout_cnt}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Basic frame with latency and busy checks
    posx = 12'd50; posy = 12'd679; start_game = 1'b0; ready = 1'b1; txd_en = 1'b1;
    exp_q.push_back(16'h1032);
    exp_q.push_back(16'h22A7);
    exp_q.push_back(16'h3000);
    tick_once();
    @(negedge clk);
    check("latency_load_valid", {31'h0, data_valid}, 32'h0);
    @(negedge clk);
    check("latency_offer_valid", {31'h0, data_valid}, 32'h1);
    check("first_word", {16'h0, data}, 32'h1032);
    i = 0;
    while (done_cnt < 1 && i < 500) begin
      check("busy_in_frame", {31'h0, busy}, 32'h1);
      @(negedge clk);
      i++;
    end
    check("frame1_done", done_cnt, 1);
    repeat (3) @(negedge clk);
    check("frame_done_once", done_cnt, 1);
    check("busy_after", {31'h0, busy}, 32'h0);
    check("queue_empty1", exp_q.size(), 0);

    // Ready held low during OFFER
    ready = 1'b0; start_game = 1'b1;
    push3(12'd50, 12'd679, 1'b1);
    tick_once();
    repeat (7) @(posedge clk);
    #1;
    check("valid_held_stall", {31'h0, data_valid}, 32'h1);
    ready = 1'b1;
    wait_done(2, "frame2_done");
    check("queue_empty2", exp_q.size(), 0);

    // Inputs change right after LOAD
    push3(12'd50, 12'd679, 1'b1);
    tick_once();
    @(posedge clk);
    #1 posx = 12'd100; posy = 12'd5; start_game = 1'b0;
    wait_done(3, "frame3_done");
    check("queue_empty3", exp_q.size(), 0);

    // Two extra ticks in one frame: one queued, one dropped
    posx = 12'h007; posy = 12'h008; start_game = 1'b0;
    push3(12'h007, 12'h008, 1'b0);
    push3(12'h007, 12'h008, 1'b0);
    base = done_cnt;
    tick_once();
    repeat (5) @(posedge clk);
    tick_once();
    repeat (5) @(posedge clk);
    tick_once();
    wait_done(base + 2, "pending_frame_done");
    repeat (5) @(negedge clk);
    check("drop_cnt_one", {24'h0, drop_cnt}, 32'h1);
    check("no_third_frame", done_cnt, base + 2);
    check("queue_empty4", exp_q.size(), 0);

    // Tick coincident with FINISH
    push3(12'h007, 12'h008, 1'b0);
    push3(12'h007, 12'h008, 1'b0);
    base = done_cnt;
    tick_once();
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (!frame_done && i < 500);
    check("finish_seen", {31'h0, frame_done}, 32'h1);
    frame_tick = 1'b1;
    @(posedge clk);
    #1 frame_tick = 1'b0;
    wait_done(base + 2, "finish_tick_frame");
    check("drop_cnt_unchanged", {24'h0, drop_cnt}, 32'h1);
    check("queue_empty5", exp_q.size(), 0);

    // tx_done never arrives
    txd_en = 1'b0;
    posx = 12'h123; posy = 12'h456; start_game = 1'b1;
    exp_q.push_back(16'h1123);
    base = done_cnt;
    tick_once();
    wait_accept("tmo_accept");
    repeat (35) @(negedge clk);
    check("busy_before_timeout", {31'h0, busy}, 32'h1);
    i = 0;
    while (busy && i < 20) begin
      @(negedge clk);
      i++;
    end
    check("busy_after_timeout", {31'h0, busy}, 32'h0);
    check("timeout_cnt_one", {24'h0, timeout_cnt}, 32'h1);
    check("no_frame_done_on_abort", done_cnt, base);
    txd_en = 1'b1;
    push3(12'h123, 12'h456, 1'b1);
    tick_once();
    wait_done(base + 1, "frame_after_timeout");
    check("queue_empty6", exp_q.size(), 0);

    // Reset while in WAIT_DONE
    txd_en = 1'b0;
    exp_q.push_back(16'h1123);
    tick_once();
    wait_accept("rst_accept");
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_data", {16'h0, data}, 32'h0);
    check("rst_flags", {29'h0, data_valid, busy, frame_done}, 32'h0);
    check("rst_counters", {16'h0, drop_cnt, timeout_cnt}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    check("queue_empty7", exp_q.size(), 0);

    // Continuous ticks with a stalled link saturate drop_cnt
    ready = 1'b0;
    @(posedge clk);
    #1 frame_tick = 1'b1;
    repeat (500) @(posedge clk);
    #1 frame_tick = 1'b0;
    @(negedge clk);
    check("drop_cnt_saturated", {24'h0, drop_cnt}, 32'hFF);
    check("timeout_cnt_nonzero", {31'h0, timeout_cnt != 8'h0}, 32'h1);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
